// File: rtl/cnt_pkg.sv
// Shared types and helpers for the modulo-N counter family.
package cnt_pkg;

  typedef enum logic {
    CNT_DOWN = 1'b0,
    CNT_UP   = 1'b1
  } cnt_dir_e;

  // Clamp a load value into 0..modulus-1; modulus is 33 bits so 2**32 is representable.
  function automatic logic [31:0] clamp_mod(input logic [31:0] val, input logic [32:0] modulus);
    logic [32:0] v;
    v = {1'b0, val};
    if (v >= modulus) begin
      return 32'(modulus - 33'd1);
    end
    return val;
  endfunction

endpackage

// File: rtl/param_mod_counter.sv
// Synchronous modulo-N up/down counter with clear, load, enable, terminal count, wrap pulse and sticky overflow.
// Define COUNTER_SAT_EN to build the saturating variant (holds at the bound, wrap tied low).
module param_mod_counter
  import cnt_pkg::*;
#(
  parameter int unsigned     WIDTH   = 4,
  parameter longint unsigned MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("param_mod_counter: WIDTH must be in 1..32");
  end
  if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("param_mod_counter: MODULUS must be in 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  cnt_dir_e         dir;
  logic             at_term;

  assign dir     = cnt_dir_e'(up);
  assign at_term = (dir == CNT_UP) ? (q_q == MAX_VAL) : (q_q == '0);

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    ovf_d  = ovf_q;
    if (clr) begin
      q_d   = '0;
      ovf_d = 1'b0;
    end else if (load) begin
      q_d = WIDTH'(clamp_mod(32'(load_val), 33'(MODULUS)));
    end else if (en) begin
      if (at_term) begin
`ifdef COUNTER_SAT_EN
        ovf_d = 1'b1;
`else
        // Explicit wrap keeps MODULUS < 2**WIDTH inside range; for full range it matches natural rollover.
        q_d    = (dir == CNT_UP) ? '0 : MAX_VAL;
        wrap_d = 1'b1;
        ovf_d  = 1'b1;
`endif
      end else begin
        q_d = (dir == CNT_UP) ? q_q + 1'b1 : q_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign q    = q_q;
  assign wrap = wrap_q;
  assign ovf  = ovf_q;
  // Combinational for zero-latency cascading into the next stage's enable.
  assign tc   = en & at_term;

endmodule

// File: tb/tb_param_mod_counter.sv
// Self-checking bench for param_mod_counter: WIDTH=4/MODULUS=10 unit plus a two-stage MODULUS=16 cascade.
`timescale 1ns/1ps
module tb_param_mod_counter;

  localparam int W = 4;
  localparam int M = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         clr, load, en, up;
  logic [W-1:0] load_val;
  logic [W-1:0] q;
  logic         tc, wrap, ovf;

  logic         c_clr, c_en;
  logic [3:0]   c_q0, c_q1;
  logic         c_tc0, c_tc1, c_wrap0, c_wrap1, c_ovf0, c_ovf1;

  param_mod_counter #(.WIDTH(W), .MODULUS(M)) u_dut (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up), .q(q), .tc(tc), .wrap(wrap), .ovf(ovf)
  );

  param_mod_counter #(.WIDTH(4), .MODULUS(16)) u_c0 (
    .clk(clk), .rst(rst), .clr(c_clr), .load(1'b0), .load_val(4'd0),
    .en(c_en), .up(1'b1), .q(c_q0), .tc(c_tc0), .wrap(c_wrap0), .ovf(c_ovf0)
  );

  param_mod_counter #(.WIDTH(4), .MODULUS(16)) u_c1 (
    .clk(clk), .rst(rst), .clr(c_clr), .load(1'b0), .load_val(4'd0),
    .en(c_tc0), .up(1'b1), .q(c_q1), .tc(c_tc1), .wrap(c_wrap1), .ovf(c_ovf1)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- reference model ----------------
  int m_q;
  bit m_wrap, m_ovf;

  task automatic model_reset();
    m_q = 0; m_wrap = 0; m_ovf = 0;
  endtask

  task automatic model_edge();
    int nxt;
    bit hit;
    if (clr) begin
      m_q = 0; m_wrap = 0; m_ovf = 0;
    end else if (load) begin
      m_q    = (int'(load_val) >= M) ? M - 1 : int'(load_val);
      m_wrap = 0;
    end else if (en) begin
      if (up) begin
        hit = (m_q + 1 == M);
        nxt = (m_q + 1) % M;
      end else begin
        hit = (m_q == 0);
        nxt = (m_q + M - 1) % M;
      end
`ifdef COUNTER_SAT_EN
      m_wrap = 0;
      if (hit) m_ovf = 1;
      else     m_q = nxt;
`else
      m_wrap = hit;
      if (hit) m_ovf = 1;
      m_q = nxt;
`endif
    end else begin
      m_wrap = 0;
    end
  endtask

  function automatic bit exp_tc();
    return en && (up ? (m_q == M - 1) : (m_q == 0));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input bit c, input bit l, input logic [W-1:0] lv, input bit e, input bit u);
    clr = c; load = l; load_val = lv; en = e; up = u;
    #1;
  endtask

  task automatic advance();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    drive(0, 0, 4'd0, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    n_cmp++; if (q !== 4'd0)  begin n_fail++; $display("FAIL reset_q: got %0d want 0", q); end
    n_cmp++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: got %0b want 0", wrap); end
    n_cmp++; if (ovf !== 1'b0)  begin n_fail++; $display("FAIL reset_ovf: got %0b want 0", ovf); end
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, 4'd0, 1, 1);
      n_cmp++; if (tc !== exp_tc()) begin n_fail++; $display("FAIL up_tc[%0d]: got %0b want %0b", i, tc, exp_tc()); end
      advance();
      n_cmp++; if (q !== W'(m_q))    begin n_fail++; $display("FAIL up_q[%0d]: got %0d want %0d", i, q, m_q); end
      n_cmp++; if (wrap !== m_wrap) begin n_fail++; $display("FAIL up_wrap[%0d]: got %0b want %0b", i, wrap, m_wrap); end
      n_cmp++; if (ovf !== m_ovf)   begin n_fail++; $display("FAIL up_ovf[%0d]: got %0b want %0b", i, ovf, m_ovf); end
    end
  endtask

  task automatic test_down();
    drive(1, 0, 4'd0, 0, 1);
    advance();
    for (int i = 0; i < 13; i++) begin
      drive(0, 0, 4'd0, (i != 12), 0);
      n_cmp++; if (tc !== exp_tc()) begin n_fail++; $display("FAIL down_tc[%0d]: got %0b want %0b", i, tc, exp_tc()); end
      advance();
      n_cmp++; if (q !== W'(m_q))    begin n_fail++; $display("FAIL down_q[%0d]: got %0d want %0d", i, q, m_q); end
      n_cmp++; if (wrap !== m_wrap) begin n_fail++; $display("FAIL down_wrap[%0d]: got %0b want %0b", i, wrap, m_wrap); end
      n_cmp++; if (ovf !== m_ovf)   begin n_fail++; $display("FAIL down_ovf[%0d]: got %0b want %0b", i, ovf, m_ovf); end
    end
  endtask

  task automatic test_load_clr();
    bit               c_t[4] = '{0, 0, 1, 0};
    bit               l_t[4] = '{1, 1, 1, 1};
    logic [W-1:0]     v_t[4] = '{4'd13, 4'd15, 4'd5, 4'd4};
    bit               e_t[4] = '{0, 1, 1, 1};
    for (int i = 0; i < 4; i++) begin
      drive(c_t[i], l_t[i], v_t[i], e_t[i], (i != 1));
      advance();
      n_cmp++; if (q !== W'(m_q))    begin n_fail++; $display("FAIL load_q[%0d]: got %0d want %0d", i, q, m_q); end
      n_cmp++; if (wrap !== m_wrap) begin n_fail++; $display("FAIL load_wrap[%0d]: got %0b want %0b", i, wrap, m_wrap); end
      n_cmp++; if (ovf !== m_ovf)   begin n_fail++; $display("FAIL load_ovf[%0d]: got %0b want %0b", i, ovf, m_ovf); end
    end
  endtask

  task automatic test_async_reset();
    for (int s = 0; s < 2; s++) begin
      drive(0, 1, 4'd0, 0, 1);
      advance();
      drive(0, 0, 4'd0, 1, 0);
      advance();
      if (s == 1) begin
        drive(0, 1, 4'd6, 0, 1);
        advance();
        n_cmp++; if (q !== 4'd6) begin n_fail++; $display("FAIL async_pre_q: got %0d want 6", q); end
      end
      drive(0, 0, 4'd0, 1, 1);
      #2 rst = 1'b0;
      #1;
      model_reset();
      n_cmp++; if (q !== 4'd0)    begin n_fail++; $display("FAIL async_q[%0d]: got %0d want 0", s, q); end
      n_cmp++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL async_wrap[%0d]: got %0b want 0", s, wrap); end
      n_cmp++; if (ovf !== 1'b0)  begin n_fail++; $display("FAIL async_ovf[%0d]: got %0b want 0", s, ovf); end
      @(posedge clk);
      #2;
      n_cmp++; if (q !== 4'd0) begin n_fail++; $display("FAIL async_hold_q[%0d]: got %0d want 0", s, q); end
      rst = 1'b1;
      #1;
    end
  endtask

  task automatic test_back_to_back();
    drive(0, 1, 4'd9, 0, 1);
    advance();
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 4'd0, 1, (i % 2 == 0));
      n_cmp++; if (tc !== exp_tc()) begin n_fail++; $display("FAIL b2b_tc[%0d]: got %0b want %0b", i, tc, exp_tc()); end
      advance();
      n_cmp++; if (q !== W'(m_q))    begin n_fail++; $display("FAIL b2b_q[%0d]: got %0d want %0d", i, q, m_q); end
      n_cmp++; if (wrap !== m_wrap) begin n_fail++; $display("FAIL b2b_wrap[%0d]: got %0b want %0b", i, wrap, m_wrap); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0, W'($urandom_range(0, 15)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
      n_cmp++; if (tc !== exp_tc()) begin n_fail++; $display("FAIL rnd_tc[%0d]: got %0b want %0b", i, tc, exp_tc()); end
      advance();
      n_cmp++; if (q !== W'(m_q))    begin n_fail++; $display("FAIL rnd_q[%0d]: got %0d want %0d", i, q, m_q); end
      n_cmp++; if (wrap !== m_wrap) begin n_fail++; $display("FAIL rnd_wrap[%0d]: got %0b want %0b", i, wrap, m_wrap); end
      n_cmp++; if (ovf !== m_ovf)   begin n_fail++; $display("FAIL rnd_ovf[%0d]: got %0b want %0b", i, ovf, m_ovf); end
    end
  endtask

  // ---------------- cascade scoreboard ----------------
  logic [7:0] exp_q[$];

  task automatic test_cascade();
    logic [7:0] exp_v;
    int         hi;
    c_en  = 1'b0;
    c_clr = 1'b1;
    @(posedge clk);
    #1;
    c_clr = 1'b0;
    n_cmp++; if ({c_q1, c_q0} !== 8'h00) begin n_fail++; $display("FAIL casc_clr: got %02h want 00", {c_q1, c_q0}); end
    c_en = 1'b1;
    for (int i = 1; i <= 260; i++) begin
`ifdef COUNTER_SAT_EN
      hi = (i <= 15) ? 0 : ((i - 15 > 15) ? 15 : i - 15);
      exp_q.push_back((i <= 15) ? 8'(i) : {4'(hi), 4'hF});
`else
      hi = 0;
      exp_q.push_back(8'(i % 256));
`endif
      n_cmp++; if (c_tc0 !== (c_q0 == 4'd15)) begin n_fail++; $display("FAIL casc_tc0[%0d]: got %0b q0=%0d", i, c_tc0, c_q0); end
      @(posedge clk);
      #1;
      exp_v = exp_q.pop_front();
      n_cmp++; if ({c_q1, c_q0} !== exp_v) begin n_fail++; $display("FAIL casc_q[%0d]: got %02h want %02h", i, {c_q1, c_q0}, exp_v); end
    end
    c_en = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    clr = 0; load = 0; load_val = '0; en = 0; up = 1;
    c_clr = 0; c_en = 0;
    test_reset();
    test_down();
    test_load_clr();
    test_async_reset();
    test_back_to_back();
    test_random();
    test_cascade();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, %0d compared so far", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
